// File: rtl/imem_loader.sv
// Instruction memory writer: streams a length-bounded byte session into a 256-byte
// array from a programmable base, and serves the big-endian 32-bit fetch port.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              fetch_hold
);

  // state | meaning
  // IDLE  | waiting for start; count holds last session's total
  // LOAD  | session active, accepting bytes
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              aborted_q, aborted_d;
  logic              we;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    count_d   = count_q;
    aborted_d = 1'b0;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          if (len != '0) begin
            state_d = LOAD;
            ptr_d   = base_addr;
            rem_d   = len;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // abort wins over a same-cycle handshake: that byte is dropped
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (byte_valid) begin
          we      = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          count_d = count_q + (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= byte_in;
  end

  logic [ADDR_W-1:0] fa1, fa2, fa3;
  assign fa1 = fetch_addr + ADDR_W'(1);
  assign fa2 = fetch_addr + ADDR_W'(2);
  assign fa3 = fetch_addr + ADDR_W'(3);

  assign fetch_instr = {mem_q[fetch_addr], mem_q[fa1], mem_q[fa2], mem_q[fa3]};

  assign byte_ready = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign fetch_hold = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign aborted    = aborted_q;
  assign count      = count_q;

endmodule
